// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: turns stack-machine ops into one-cycle push/pop pulses on an external stack
module stack_op_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1023,
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_imm,
  output logic               stk_push,
  output logic               stk_pop,
  output logic [WIDTH-1:0]   stk_din,
  input  logic [WIDTH-1:0]   stk_dout,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  output logic [DEPTH_W-1:0] depth
);
  localparam logic [2:0] OP_NOP = 3'd0, OP_PUSH = 3'd1, OP_POP = 3'd2, OP_ADD = 3'd3,
                         OP_SUB = 3'd4, OP_AND = 3'd5, OP_NOT = 3'd6, OP_DUP = 3'd7;
  typedef enum logic [2:0] {IDLE, POP1, CAP, POP2, PUSH, SETTLE, DONE} state_t;
  state_t st;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, alu;
  logic [DEPTH_W-1:0] step;
  logic need1, need2, grow, fail;
  always_comb begin
    need2 = cmd_op == OP_ADD || cmd_op == OP_SUB || cmd_op == OP_AND;
    need1 = cmd_op == OP_POP || cmd_op == OP_NOT || cmd_op == OP_DUP;
    grow = cmd_op == OP_PUSH || cmd_op == OP_DUP;
    fail = (need2 && depth < DEPTH_W'(2)) || (need1 && depth == '0) || (grow && depth >= DEPTH_W'(DEPTH));
    alu = op == OP_ADD ? b + a : op == OP_SUB ? b - a : op == OP_AND ? b & a : ~a;
    // all-ones step is -1 modulo 2**DEPTH_W
    step = err ? '0 : (op == OP_PUSH || op == OP_DUP) ? DEPTH_W'(1) :
           (op == OP_POP || op == OP_ADD || op == OP_SUB || op == OP_AND) ? '1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cmd_ready <= 1'b1;
      stk_push <= 1'b0;
      stk_pop <= 1'b0;
      stk_din <= '0;
      done <= 1'b0;
      err <= 1'b0;
      result <= '0;
      depth <= '0;
      op <= OP_NOP;
      a <= '0;
      b <= '0;
    end else begin
      stk_push <= 1'b0;
      stk_pop <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      case (st)
        IDLE: if (cmd_valid) begin
          op <= cmd_op;
          a <= stk_dout;
          cmd_ready <= 1'b0;
          if (fail || cmd_op == OP_NOP) begin
            st <= DONE;
            done <= 1'b1;
            err <= fail;
          end else if (grow) begin
            st <= PUSH;
            stk_push <= 1'b1;
            stk_din <= cmd_op == OP_PUSH ? cmd_imm : stk_dout;
          end else begin
            st <= POP1;
            stk_pop <= 1'b1;
          end
        end
        POP1: if (op == OP_POP) st <= SETTLE;
          else if (op == OP_NOT) begin
            st <= PUSH;
            stk_push <= 1'b1;
            stk_din <= alu;
          end else st <= CAP;
        CAP: begin
          b <= stk_dout;
          st <= POP2;
          stk_pop <= 1'b1;
        end
        POP2: begin
          st <= PUSH;
          stk_push <= 1'b1;
          stk_din <= alu;
        end
        PUSH: st <= SETTLE;
        SETTLE: begin
          st <= DONE;
          done <= 1'b1;
          result <= op == OP_POP ? a : stk_din;
        end
        default: begin
          st <= IDLE;
          cmd_ready <= 1'b1;
          depth <= depth + step;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: scoreboard bench with a behavioural stack behind the sequencer
`timescale 1ns/1ps
module tb_stack_op_sequencer;
  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, ADD = 3'd3,
                         SUB = 3'd4, AND = 3'd5, NOT = 3'd6, DUP = 3'd7;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_ready, stk_push, stk_pop, done, err;
  logic [2:0] cmd_op = 0;
  logic [7:0] cmd_imm = 0, stk_din, stk_dout, result;
  logic [9:0] depth;
  int vecs = 0, fails = 0, npush = 0, npop = 0, sp = 0;
  bit ppush = 0, ppop = 0, pend = 0;
  int pend_dep;
  logic [7:0] mem [0:1023];
  typedef struct {string name; int lat; bit e; logic [7:0] r; int dep; int np; int npp; time t; int bp; int bpp;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  stack_op_sequencer dut (.clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .done(done), .result(result), .err(err), .depth(depth));

  always @(posedge clk)
    if (rst) sp <= 0;
    else if (stk_push) begin mem[sp] <= stk_din; sp <= sp + 1; end
    else if (stk_pop) sp <= sp - 1;
  assign stk_dout = sp == 0 ? 8'h00 : mem[sp-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stk_push && stk_pop) begin fails++; $display("FAIL pins_overlap: push=1 pop=1 expected never both"); end
    if (stk_push && ppush) begin fails++; $display("FAIL push_2cycle: got two-cycle push expected one"); end
    if (stk_pop && ppop) begin fails++; $display("FAIL pop_2cycle: got two-cycle pop expected one"); end
    if (stk_push) npush++;
    if (stk_pop) npop++;
    ppush = stk_push;
    ppop = stk_pop;
  end

  always @(negedge clk) if (!rst) begin
    exp_t x;
    if (pend) begin
      chk("depth", 32'(depth), pend_dep);
      pend = 0;
    end
    if (done) begin
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got done with op=%0d expected none", cmd_op);
      end else begin
        x = sb.pop_front();
        chk({x.name, "_err"}, 32'(err), 32'(x.e));
        chk({x.name, "_result"}, 32'(result), 32'(x.r));
        chk({x.name, "_latency"}, 32'(($time - x.t + 5) / 10), x.lat);
        chk({x.name, "_pushes"}, npush - x.bp, x.np);
        chk({x.name, "_pops"}, npop - x.bpp, x.npp);
        pend = 1;
        pend_dep = x.dep;
      end
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [7:0] imm, input bit e, input logic [7:0] r,
                       input int dep, input int lat, input int np, input int npp, input string nm);
    exp_t x;
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) begin fails++; $display("FAIL %s_ready_timeout: got cmd_ready=0 expected 1", nm); return; end
    cmd_valid = 1; cmd_op = o; cmd_imm = imm;
    @(posedge clk);
    x = '{nm, lat, e, r, dep, np, npp, $time, npush, npop};
    sb.push_back(x);
    n = 0;
    // valid stays high while busy: a second accept would show up as an extra done
    do begin @(negedge clk); n++; end while (!done && n < 20);
    if (!done) begin fails++; void'(sb.pop_front()); $display("FAIL %s_done_timeout: got no done expected done", nm); end
    cmd_valid = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_pins", 32'({stk_push, stk_pop}), 0);
    rst = 0;
    do_op(PUSH, 8'h05, 0, 8'h05, 1, 3, 1, 0, "push05");
    do_op(PUSH, 8'h03, 0, 8'h03, 2, 3, 1, 0, "push03");
    do_op(SUB, 8'h00, 0, 8'h02, 1, 6, 1, 2, "sub");
    do_op(ADD, 8'h00, 1, 8'h02, 1, 1, 0, 0, "add_under");
    do_op(POP, 8'h00, 0, 8'h02, 0, 3, 0, 1, "pop02");
    do_op(PUSH, 8'h01, 0, 8'h01, 1, 3, 1, 0, "push01");
    do_op(PUSH, 8'hFF, 0, 8'hFF, 2, 3, 1, 0, "pushff");
    do_op(ADD, 8'h00, 0, 8'h00, 1, 6, 1, 2, "add_wrap");
    do_op(NOT, 8'h00, 0, 8'hFF, 1, 4, 1, 1, "not");
    do_op(DUP, 8'h00, 0, 8'hFF, 2, 3, 1, 0, "dup");
    do_op(PUSH, 8'h0F, 0, 8'h0F, 3, 3, 1, 0, "push0f");
    do_op(AND, 8'h00, 0, 8'h0F, 2, 6, 1, 2, "and");
    do_op(NOP, 8'h00, 0, 8'h0F, 2, 1, 0, 0, "nop");
    do_op(POP, 8'h00, 0, 8'h0F, 1, 3, 0, 1, "pop0f");
    do_op(POP, 8'h00, 0, 8'hFF, 0, 3, 0, 1, "popff");
    do_op(POP, 8'h00, 1, 8'hFF, 0, 1, 0, 0, "pop_empty");
    do_op(NOT, 8'h00, 1, 8'hFF, 0, 1, 0, 0, "not_empty");
    for (int i = 0; i < 1023; i++) do_op(PUSH, i[7:0], 0, i[7:0], i + 1, 3, 1, 0, "fill");
    do_op(PUSH, 8'hAA, 1, 8'hFE, 1023, 1, 0, 0, "push_full");
    do_op(DUP, 8'h00, 1, 8'hFE, 1023, 1, 0, 0, "dup_full");
    do_op(POP, 8'h00, 0, 8'hFE, 1022, 3, 0, 1, "pop_full");
    do_op(SUB, 8'h00, 0, 8'hFF, 1021, 6, 1, 2, "sub_borrow");
    @(negedge clk);
    cmd_valid = 1; cmd_op = AND;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("and_pop2_pin", 32'(stk_pop), 1);
    rst = 1;
    @(negedge clk);
    chk("abort_pins", 32'({stk_push, stk_pop}), 0);
    chk("abort_ready", 32'(cmd_ready), 1);
    chk("abort_depth", 32'(depth), 0);
    chk("abort_done", 32'(done), 0);
    rst = 0;
    do_op(PUSH, 8'h07, 0, 8'h07, 1, 3, 1, 0, "push_after_rst");
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
